// File: rtl/ord_tx_arb.sv
// ord_tx_arb
//   Round-robin arbiter that moves orders from NUM_REQ strategy engines onto
//   one registered output stage. Every grant spends one token from a global
//   token bucket, which bounds the order rate toward the exchange gateway.
//
// Ports
//   clk, reset         rising-edge clock, asynchronous active-high reset
//   cfg_enable         1 = new grants allowed (output stage always drains)
//   req_valid/_data    per-engine order; engine i at [i*ORD_WIDTH +: ORD_WIDTH]
//   req_ready          combinational accept, one-hot or zero
//   out_valid/_data    registered order toward the gateway
//   out_src            engine index that issued out_data
//   out_ready          downstream accept
//   tokens             current bucket level
//   throttled          registered: some engine requesting while bucket empty
module ord_tx_arb #(
    parameter  int NUM_REQ       = 4,
    parameter  int ORD_WIDTH     = 128,
    parameter  int TOKEN_MAX     = 8,
    parameter  int REFILL_PERIOD = 16,
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int TW = $clog2(TOKEN_MAX + 1),
    localparam int CW = (REFILL_PERIOD > 1) ? $clog2(REFILL_PERIOD) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           cfg_enable,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*ORD_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           out_valid,
    output logic [ORD_WIDTH-1:0]           out_data,
    output logic [PW-1:0]                  out_src,
    input  logic                           out_ready,
    output logic [TW-1:0]                  tokens,
    output logic                           throttled
);

    logic [PW-1:0] ptr;
    logic [CW-1:0] refill_cnt;
    logic          refill;
    logic          free;
    logic          grant;
    logic          sel_found;
    logic [PW-1:0] sel_idx;
    int            idx;

    // Rotating search: start just after the last granted engine so that a
    // lone requester equal to ptr is still found on the final iteration.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        idx       = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!sel_found && req_valid[idx]) begin
                sel_found = 1'b1;
                sel_idx   = PW'(idx);
            end
        end
    end

    assign free      = !out_valid || out_ready;
    // reset is folded in so req_ready stays low for the whole reset pulse.
    assign grant     = !reset && cfg_enable && (tokens != '0) && free && sel_found;
    assign req_ready = grant ? (NUM_REQ'(1) << sel_idx) : '0;
    assign refill    = (refill_cnt == CW'(REFILL_PERIOD - 1));

    // Free-running refill counter; keeps running while cfg_enable is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) refill_cnt <= '0;
        else       refill_cnt <= refill ? '0 : refill_cnt + 1'b1;
    end

    // Token bucket: refill and consume in the same cycle cancel out, and a
    // refill at a full bucket is dropped rather than banked.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tokens <= TW'(TOKEN_MAX);
        end else begin
            case ({refill, grant})
                2'b10:   if (tokens != TW'(TOKEN_MAX)) tokens <= tokens + 1'b1;
                2'b01:   tokens <= tokens - 1'b1;
                default: tokens <= tokens;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) throttled <= 1'b0;
        else       throttled <= (|req_valid) && (tokens == '0);
    end

    // Output stage and round-robin pointer. Starting ptr at the top index
    // gives engine 0 first priority after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            ptr       <= PW'(NUM_REQ - 1);
        end else if (grant) begin
            out_valid <= 1'b1;
            out_data  <= req_data[sel_idx*ORD_WIDTH +: ORD_WIDTH];
            out_src   <= sel_idx;
            ptr       <= sel_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
